memory_system: RTL and testbench

MEMORY_SYSTEM -- requirements
Module: memory_system

---
 rtl/memory_system_pkg.sv | 13 +
 rtl/sync_ram.sv | 23 ++
 rtl/memory_system.sv | 105 ++++++++++
 tb/tb_memory_system.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_system_pkg.sv
// Shared types and constants for the
// instruction/data memory subsystem.
package memory_system_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP = 16'h0000;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_ram.sv
// Single-write-port RAM with a
// combinational read port; no reset.
module sync_ram #(
  parameter int W  = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_system.sv
// Boot-loaded instruction memory plus
// data memory with range checking.
module memory_system
  import memory_system_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instrAddr,
  output logic [15:0]       instruction,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [15:0]       dataAddr,
  input  logic [15:0]       datain,
  output logic [15:0]       dataout,
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic [IMEM_AW:0]  load_count,
  output logic              addr_err
);

  localparam logic [IMEM_AW:0] LAST_PTR =
    (IMEM_AW+1)'((1 << IMEM_AW) - 1);

  state_t state, state_nx;
  logic   run, accept;
  logic   i_ok, d_ok, d_acc;
  logic [WORD_W-1:0] i_rd, d_rd;

  assign run    = (state == RUN);
  assign accept = ld_valid && ld_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:
        if (accept &&
            (ld_last || load_count == LAST_PTR))
          state_nx = RUN;
      RUN: state_nx = RUN;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    cpu_hold = 1'b0;
    unique case (state)
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      RUN: ;
      default: ;
    endcase
  end

  // Acceptance is only possible in LOAD,
  // so the pointer stops at 2^IMEM_AW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      load_count <= '0;
    else if (accept) load_count <= load_count + 1'b1;
  end

  assign i_ok  = (instrAddr >> IMEM_AW) == 16'h0;
  assign d_ok  = (dataAddr >> DMEM_AW) == 16'h0;
  assign d_acc = run && (MemRd || MemWr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              addr_err <= 1'b0;
    else if (d_acc && !d_ok) addr_err <= 1'b1;
  end

  sync_ram #(.W(WORD_W), .AW(IMEM_AW)) imem (
    .clk   (clk),
    .we    (accept),
    .waddr (load_count[IMEM_AW-1:0]),
    .wdata (ld_data),
    .raddr (instrAddr[IMEM_AW-1:0]),
    .rdata (i_rd)
  );

  sync_ram #(.W(WORD_W), .AW(DMEM_AW)) dmem (
    .clk   (clk),
    .we    (run && MemWr && d_ok),
    .waddr (dataAddr[DMEM_AW-1:0]),
    .wdata (datain),
    .raddr (dataAddr[DMEM_AW-1:0]),
    .rdata (d_rd)
  );

  assign instruction = (run && i_ok) ? i_rd : NOP;
  assign dataout = (run && MemRd && d_ok) ? d_rd : NOP;

endmodule

// File: tb/tb_memory_system.sv
// Self-checking bench: loader, data RAM
// vectors, range, reset and gating.
module tb_memory_system;

  localparam int IAW = 2;
  localparam int DAW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instrAddr, instruction;
  logic        MemRd, MemWr;
  logic [15:0] dataAddr, datain, dataout;
  logic        ld_valid, ld_last;
  logic [15:0] ld_data;
  logic        ld_ready, cpu_hold, addr_err;
  logic [IAW:0] load_count;

  int total = 0;
  int passed = 0;

  memory_system #(.IMEM_AW(IAW), .DMEM_AW(DAW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instrAddr   (instrAddr),
    .instruction (instruction),
    .MemRd       (MemRd),
    .MemWr       (MemWr),
    .dataAddr    (dataAddr),
    .datain      (datain),
    .dataout     (dataout),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .cpu_hold    (cpu_hold),
    .load_count  (load_count),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] dout;
    logic        err;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  n, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] d,
                           input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic imem_chk(input string n,
                          input logic [15:0] a,
                          input logic [15:0] e);
    instrAddr = a;
    #1;
    chk(n, {16'h0, instruction}, {16'h0, e});
  endtask

  task automatic dmem_rd(input string n,
                         input logic [15:0] a,
                         input logic [15:0] e);
    MemRd = 1'b1;
    MemWr = 1'b0;
    dataAddr = a;
    #1;
    chk(n, {16'h0, dataout}, {16'h0, e});
    MemRd = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    #2;
    chk("async_rst_count", 32'(load_count), 32'd0);
    chk("async_rst_hold", 32'(cpu_hold), 32'd1);
    chk("async_rst_err", 32'(addr_err), 32'd0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"wr0", 0, 1, 16'h0000, 16'h0A0A, 16'h0000, 0};
    vecs[1]  = '{"wr5", 0, 1, 16'h0005, 16'hBEEF, 16'h0000, 0};
    vecs[2]  = '{"rd5", 1, 0, 16'h0005, 16'h0000, 16'hBEEF, 0};
    vecs[3]  = '{"rw5", 1, 1, 16'h0005, 16'h1234, 16'hBEEF, 0};
    vecs[4]  = '{"rd5b", 1, 0, 16'h0005, 16'h0000, 16'h1234, 0};
    vecs[5]  = '{"rd0", 1, 0, 16'h0000, 16'h0000, 16'h0A0A, 0};
    vecs[6]  = '{"wrFF", 0, 1, 16'h00FF, 16'h5A5A, 16'h0000, 0};
    vecs[7]  = '{"rdFF", 1, 0, 16'h00FF, 16'h0000, 16'h5A5A, 0};
    vecs[8]  = '{"wr100", 0, 1, 16'h0100, 16'hFFFF, 16'h0000, 0};
    vecs[9]  = '{"rd0_err", 1, 0, 16'h0000, 16'h0000, 16'h0A0A, 1};
    vecs[10] = '{"rd100", 1, 0, 16'h0100, 16'h0000, 16'h0000, 1};
    vecs[11] = '{"rdFF_err", 1, 0, 16'h00FF, 16'h0000, 16'h5A5A, 1};

    reset = 1'b1;
    instrAddr = '0;
    MemRd = 1'b0;
    MemWr = 1'b0;
    dataAddr = '0;
    datain = '0;
    ld_valid = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    #1;
    reset = 1'b0;
    #2;
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_instr", {16'h0, instruction}, 32'h0);
    tick();
    tick();
    reset = 1'b1;

    load_word(16'h1111, 1'b0);
    chk("ld1_count", 32'(load_count), 32'd1);
    chk("ld1_hold", 32'(cpu_hold), 32'd1);
    load_word(16'h2222, 1'b0);
    chk("ld2_count", 32'(load_count), 32'd2);
    load_word(16'h3333, 1'b1);
    chk("ld3_count", 32'(load_count), 32'd3);
    chk("ld3_hold", 32'(cpu_hold), 32'd0);
    chk("ld3_ready", 32'(ld_ready), 32'd0);
    imem_chk("imem1", 16'd1, 16'h2222);
    imem_chk("imem0", 16'd0, 16'h1111);
    imem_chk("imem2", 16'd2, 16'h3333);
    imem_chk("imem_oor", 16'd4, 16'h0000);

    foreach (vecs[i]) begin
      MemRd = vecs[i].rd;
      MemWr = vecs[i].wr;
      dataAddr = vecs[i].addr;
      datain = vecs[i].din;
      sb.push_back('{vecs[i].name,
                     vecs[i].exp_dout,
                     vecs[i].exp_err});
      #2;
      begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_dout"}, {16'h0, dataout},
            {16'h0, e.dout});
        chk({e.name, "_err"}, 32'(addr_err),
            32'(e.err));
      end
      tick();
    end
    MemRd = 1'b0;
    MemWr = 1'b0;

    // Overflow of a 4-deep imem.
    pulse_reset();
    MemWr = 1'b1;
    MemRd = 1'b1;
    dataAddr = 16'h0000;
    datain = 16'hDEAD;
    instrAddr = 16'd0;
    #1;
    chk("load_dout", {16'h0, dataout}, 32'h0);
    chk("load_instr", {16'h0, instruction}, 32'h0);
    tick();
    MemWr = 1'b0;
    MemRd = 1'b0;
    ld_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ld_data = 16'hA000 + 16'(k);
      if (k == 4) begin
        #1;
        chk("ovf5_ready", 32'(ld_ready), 32'd0);
      end
      tick();
      if (k == 3) begin
        chk("ovf4_count", 32'(load_count), 32'd4);
        chk("ovf4_hold", 32'(cpu_hold), 32'd0);
      end
    end
    ld_valid = 1'b0;
    chk("ovf5_count", 32'(load_count), 32'd4);
    imem_chk("ovf_imem0", 16'd0, 16'hA000);
    imem_chk("ovf_imem3", 16'd3, 16'hA003);
    dmem_rd("gate_dmem0", 16'h0000, 16'h0A0A);
    dmem_rd("keep_dmem5", 16'h0005, 16'h1234);

    // Reset in the middle of a load.
    pulse_reset();
    load_word(16'hB000, 1'b0);
    load_word(16'hB001, 1'b0);
    chk("mid_count2", 32'(load_count), 32'd2);
    pulse_reset();
    load_word(16'hC000, 1'b1);
    chk("mid_count1", 32'(load_count), 32'd1);
    chk("mid_hold", 32'(cpu_hold), 32'd0);
    imem_chk("mid_imem0", 16'd0, 16'hC000);
    imem_chk("mid_imem1", 16'd1, 16'hB001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
